// File: rtl/stream_frame_packer.sv
// Packs narrow accelerator beats into wide host-bus beats with runtime frame length,
// lane-keep mask on the trailing partial beat and a completed-frame counter.
module stream_frame_packer #(
    parameter int IN_W    = 64,
    parameter int RATIO   = 8,
    parameter int FRAME_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [FRAME_W-1:0]    cfg_frame_beats,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_W-1:0]       s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [IN_W*RATIO-1:0] m_data,
    output logic [RATIO-1:0]      m_keep,
    output logic                  m_last,
    output logic [31:0]           frame_count
);

    localparam int                 OUT_W      = IN_W * RATIO;
    localparam int                 LANE_W     = $clog2(RATIO);
    localparam logic [LANE_W-1:0]  LAST_LANE  = LANE_W'(RATIO - 1);
    localparam logic [LANE_W-1:0]  LANE_INC   = LANE_W'(32'd1);
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(32'd1);
    localparam logic [FRAME_W-1:0] FRAME_ZERO = {FRAME_W{1'b0}};

    logic [OUT_W-1:0]   r_acc;
    logic [LANE_W-1:0]  r_lane;
    logic [FRAME_W-1:0] r_beat;
    logic [FRAME_W-1:0] r_len;
    logic               r_m_valid;
    logic [OUT_W-1:0]   r_m_data;
    logic [RATIO-1:0]   r_m_keep;
    logic               r_m_last;
    logic [31:0]        r_frame_count;

    logic [FRAME_W-1:0] w_eff_cfg;
    logic [FRAME_W-1:0] w_len;
    logic               w_frame_end;
    logic               w_completing;
    logic               w_accept;
    logic               w_load;
    logic [OUT_W-1:0]   w_new_data;
    logic [RATIO-1:0]   w_new_keep;

    // Frame length applies from the first beat of a frame, so use the live config there.
    always_comb begin
        if (cfg_frame_beats == FRAME_ZERO) begin
            w_eff_cfg = FRAME_ONE;
        end else begin
            w_eff_cfg = cfg_frame_beats;
        end
        if (r_beat == FRAME_ZERO) begin
            w_len = w_eff_cfg;
        end else begin
            w_len = r_len;
        end
        w_frame_end  = (r_beat == (w_len - FRAME_ONE));
        w_completing = w_frame_end | (r_lane == LAST_LANE);
        s_ready      = !reset & (!w_completing | !r_m_valid | m_ready);
        w_accept     = s_valid & s_ready;
        w_load       = w_accept & w_completing;
    end

    // Merge the incoming beat into its lane; lanes past it are forced to zero.
    always_comb begin
        w_new_data = {OUT_W{1'b0}};
        w_new_keep = {RATIO{1'b0}};
        for (int k = 0; k < RATIO; k++) begin
            if (LANE_W'(k) == r_lane) begin
                w_new_data[k*IN_W +: IN_W] = s_data;
                w_new_keep[k]              = 1'b1;
            end else if (LANE_W'(k) < r_lane) begin
                w_new_data[k*IN_W +: IN_W] = r_acc[k*IN_W +: IN_W];
                w_new_keep[k]              = 1'b1;
            end else begin
                w_new_data[k*IN_W +: IN_W] = {IN_W{1'b0}};
                w_new_keep[k]              = 1'b0;
            end
        end
    end

    // Input side: accumulator, lane index, beat counter and latched frame length.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc  <= {OUT_W{1'b0}};
            r_lane <= {LANE_W{1'b0}};
            r_beat <= FRAME_ZERO;
            r_len  <= FRAME_ZERO;
        end else if (w_accept) begin
            if (r_beat == FRAME_ZERO) begin
                r_len <= w_eff_cfg;
            end
            if (w_completing) begin
                r_acc  <= {OUT_W{1'b0}};
                r_lane <= {LANE_W{1'b0}};
            end else begin
                r_acc  <= w_new_data;
                r_lane <= r_lane + LANE_INC;
            end
            if (w_frame_end) begin
                r_beat <= FRAME_ZERO;
            end else begin
                r_beat <= r_beat + FRAME_ONE;
            end
        end
    end

    // Output register: a load may coincide with a drain for full throughput.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_m_valid     <= 1'b0;
            r_m_data      <= {OUT_W{1'b0}};
            r_m_keep      <= {RATIO{1'b0}};
            r_m_last      <= 1'b0;
            r_frame_count <= 32'd0;
        end else begin
            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_new_data;
                r_m_keep  <= w_new_keep;
                r_m_last  <= w_frame_end;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (r_m_valid && m_ready && r_m_last) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
        end
    end

    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_keep      = r_m_keep;
    assign m_last      = r_m_last;
    assign frame_count = r_frame_count;

endmodule

// File: doc/stream_frame_packer.md
Name: stream_frame_packer

Overview:
- Parametrised successor to the fixed 64-to-512 output width converter and free-running 64-beat last counter on the accelerator return path.
- Packs narrow result beats from the accelerator output FIFO into wide host-bus beats.
- Frames the stream with a runtime-programmable frame length. Asserts last on the true final beat of each frame and zero-pads a trailing partial wide beat with a lane-keep mask.
- Sits between the accelerator output FIFO and the DMA read-data return.

Parameters:
- IN_W, 64, narrow input beat width in bits.
- RATIO, 8, narrow lanes per wide beat; output width is IN_W*RATIO. Legal values are 2 or greater.
- FRAME_W, 16, width of the frame-length configuration and the internal beat counter.

Ports:
- clock, input, 1, sole clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- cfg_frame_beats, input, FRAME_W, narrow beats per frame; 0 is treated as 1.
- s_valid, input, 1, narrow beat valid.
- s_ready, output, 1, narrow beat accepted when s_valid and s_ready are both high.
- s_data, input, IN_W, narrow beat data.
- m_valid, output, 1, wide beat valid.
- m_ready, input, 1, downstream ready.
- m_data, output, IN_W*RATIO, wide beat; lane k occupies bits [k*IN_W +: IN_W].
- m_keep, output, RATIO, bit k set means lane k carries data.
- m_last, output, 1, final wide beat of a frame.
- frame_count, output, 32, completed frames, counted at the m_last handshake.

Behaviour:
- Reset:
  - Clocked while reset is high: m_valid, m_data, m_keep, m_last, frame_count, lane index and beat counter all go to 0; any partial accumulation is discarded.
  - s_ready is 0 while reset is high.
  - A reset in mid-frame drops the partial frame. The first beat after reset starts a new frame at lane 0.
- Frame length:
  - Latched from cfg_frame_beats when the first beat of a frame is accepted.
  - Changes to cfg_frame_beats mid-frame take effect at the next frame.
- Packing:
  - Accepted narrow beats fill lanes 0, 1, 2, ... of an accumulator register in arrival order.
  - A beat is "completing" if it fills lane RATIO-1 or is the last beat of the frame (beat counter = latched length - 1).
- Transfer on a completing beat, in the same cycle:
  - Accumulator plus the new lane load the output register.
  - m_valid is 1 next cycle; latency is 1 cycle from the completing input handshake.
  - m_keep has bits [lane:0] set and all others 0; unfilled lanes are 0 in m_data.
  - m_last = 1 if the beat ended the frame.
  - Lane index resets to 0. The beat counter resets to 0 on frame end; otherwise it keeps counting.
- Non-completing beats only write the accumulator; they never stall on the output side.
- s_ready = !reset & (!next_is_completing | !m_valid | m_ready). This contains a combinational m_ready-to-s_ready path, and it is permitted. s_ready never depends on s_valid.
- Output handshake:
  - m_data, m_keep and m_last hold stable while m_valid is high and m_ready is low.
  - A handshake with no simultaneous load clears m_valid.
  - A handshake with a simultaneous load keeps m_valid high with the new contents, giving full throughput (one wide beat per RATIO input cycles).
- frame_count increments by 1 on each m_valid & m_ready & m_last and wraps from 2^32-1 to 0.
- Frame lengths not a multiple of RATIO produce a partial last beat. Frames shorter than RATIO produce a single partial beat with m_last set.
- Ordering is strict; no beat is dropped or duplicated under any m_ready pattern.

Test Plan:
1. RATIO=8, cfg=16, s_data=0..15 back-to-back, m_ready=1:
   - Beat 1: lanes 0..7 = 0..7, m_keep=0xFF, m_last=0, arriving 1 cycle after input 7.
   - Beat 2: lanes 0..7 = 8..15, m_keep=0xFF, m_last=1.
   - frame_count=1.
2. cfg=10, data 0..9:
   - Beat 1: m_keep=0xFF, m_last=0.
   - Beat 2: lanes 0..1 = 8,9, lanes 2..7 = 0, m_keep=0x03, m_last=1.
3. cfg=0, data A,B,C: three wide beats, each m_keep=0x01, m_last=1, lane 0 = A/B/C; frame_count=3.
4. cfg=16, s_valid continuous, m_ready=0 for 30 cycles then 1:
   - s_ready drops when the 16th beat would complete; the first beat stays held stable.
   - After release, 2 beats arrive in order with data 0..15 intact.
5. cfg=16, change cfg to 4 after 5 accepted beats: the frame still ends at beat 16 (m_last on the 2nd wide beat). The next frame has 4 beats, giving m_keep=0x0F, m_last=1.
6. Assert reset for 1 cycle after 3 beats of a cfg=16 frame:
   - Next cycle m_valid=0 and frame_count=0.
   - Then 8 new beats 0x10..0x17 produce lanes 0..7 = 0x10..0x17 with m_last=0.
